// File: rtl/pwm_out.sv
// Three-channel LED PWM driver with a shared period counter.
// Duty values are double-buffered and only take effect at the period wrap.
module pwm_out #(
  parameter int unsigned PERIOD     = 100000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] pwm_value_r,
  input  logic signed [31:0] pwm_value_g,
  input  logic signed [31:0] pwm_value_b,
  output logic               led_r,
  output logic               led_g,
  output logic               led_b,
  output logic               period_start,
  output logic        [31:0] duty_r,
  output logic        [31:0] duty_g,
  output logic        [31:0] duty_b
);

  localparam int unsigned VAL_W = 32;
  localparam int unsigned NCH   = 3;

  localparam logic        [VAL_W-1:0] CNT_LAST = VAL_W'(PERIOD - 1);
  localparam logic signed [VAL_W-1:0] PERIOD_S = VAL_W'(PERIOD);

  logic        [VAL_W-1:0]           cnt_q, cnt_d;
  logic [NCH-1:0][VAL_W-1:0]         duty_q, duty_d;
  logic [NCH-1:0]                    led_q, led_d;
  logic                              period_start_q, period_start_d;
  logic                              wrap_c;
  logic signed [VAL_W-1:0]           pwm_val_c [NCH];

  // Saturate a signed request into the legal duty range 0..PERIOD.
  function automatic logic [VAL_W-1:0] clamp(input logic signed [VAL_W-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > PERIOD_S) begin
      return VAL_W'(PERIOD_S);
    end else begin
      return VAL_W'(v);
    end
  endfunction

  assign pwm_val_c[0] = pwm_value_r;
  assign pwm_val_c[1] = pwm_value_g;
  assign pwm_val_c[2] = pwm_value_b;

  always_comb begin
    wrap_c         = (cnt_q == CNT_LAST);
    cnt_d          = wrap_c ? '0 : cnt_q + VAL_W'(1);
    period_start_d = wrap_c;
    duty_d         = duty_q;
    led_d          = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      led_d[i] = (cnt_q < duty_q[i]) ^ ACTIVE_LOW;
      if (wrap_c) begin
        duty_d[i] = clamp(pwm_val_c[i]);
      end
    end
  end

  // Reset wins over a coincident wrap; LEDs park in their off level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      led_q          <= {NCH{ACTIVE_LOW}};
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

  assign led_r        = led_q[0];
  assign led_g        = led_q[1];
  assign led_b        = led_q[2];
  assign period_start = period_start_q;
  assign duty_r       = duty_q[0];
  assign duty_g       = duty_q[1];
  assign duty_b       = duty_q[2];

endmodule

// File: tb/tb_pwm_out.sv
// Scoreboard bench for pwm_out: expected samples are queued per cycle by the
// stimulus and compared by an independent negedge monitor.
module tb_pwm_out;

  typedef struct {
    int unsigned     dut;
    string           name;
    logic [2:0]      led;
    logic            ps;
    logic [2:0][31:0] duty;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [31:0] val_r = 0, val_g = 0, val_b = 0;

  logic        led_r0, led_g0, led_b0, ps0;
  logic [31:0] duty_r0, duty_g0, duty_b0;
  logic        led_r1, led_g1, led_b1, ps1;
  logic [31:0] duty_r1, duty_g1, duty_b1;
  logic        led_r2, led_g2, led_b2, ps2;
  logic [31:0] duty_r2, duty_g2, duty_b2;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  pwm_out #(.PERIOD(10), .ACTIVE_LOW(1'b0)) dut_p10 (
    .clk(clk), .rst_n(rst_n),
    .pwm_value_r(val_r), .pwm_value_g(val_g), .pwm_value_b(val_b),
    .led_r(led_r0), .led_g(led_g0), .led_b(led_b0), .period_start(ps0),
    .duty_r(duty_r0), .duty_g(duty_g0), .duty_b(duty_b0)
  );

  pwm_out #(.PERIOD(10), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n),
    .pwm_value_r(val_r), .pwm_value_g(val_g), .pwm_value_b(val_b),
    .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .period_start(ps1),
    .duty_r(duty_r1), .duty_g(duty_g1), .duty_b(duty_b1)
  );

  pwm_out #(.PERIOD(2), .ACTIVE_LOW(1'b0)) dut_p2 (
    .clk(clk), .rst_n(rst_n),
    .pwm_value_r(val_r), .pwm_value_g(val_g), .pwm_value_b(val_b),
    .led_r(led_r2), .led_g(led_g2), .led_b(led_b2), .period_start(ps2),
    .duty_r(duty_r2), .duty_g(duty_g2), .duty_b(duty_b2)
  );

  function automatic logic [2:0][31:0] d3(input logic [31:0] r, input logic [31:0] g,
                                          input logic [31:0] b);
    return {b, g, r};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: one expected sample per clock, taken mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0]       a_led;
    logic             a_ps;
    logic [2:0][31:0] a_duty;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0: begin
          a_led = {led_b0, led_g0, led_r0}; a_ps = ps0; a_duty = {duty_b0, duty_g0, duty_r0};
        end
        1: begin
          a_led = {led_b1, led_g1, led_r1}; a_ps = ps1; a_duty = {duty_b1, duty_g1, duty_r1};
        end
        default: begin
          a_led = {led_b2, led_g2, led_r2}; a_ps = ps2; a_duty = {duty_b2, duty_g2, duty_r2};
        end
      endcase
      chk({e.name, ".led"}, 96'(a_led), 96'(e.led));
      chk({e.name, ".period_start"}, 96'(a_ps), 96'(e.ps));
      chk({e.name, ".duty"}, a_duty, e.duty);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned dut, input string name, input logic [2:0] led,
                          input logic ps, input logic [2:0][31:0] duty);
    exp_t e;
    e.dut  = dut;
    e.name = name;
    e.led  = led;
    e.ps   = ps;
    e.duty = duty;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int unsigned dut, input bit al, input int n);
    rst_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      push_exp(dut, "reset", {3{al}}, 1'b0, '0);
      step();
    end
    rst_n = 1'b1;
  endtask

  // Sample j of a period: LED on for j < duty, period_start and the new
  // duty appear together on the last sample of the period.
  task automatic run_frame(input int unsigned dut, input int p, input bit al,
                           input logic [2:0][31:0] cur, input logic [2:0][31:0] nxt,
                           input int j0, input int j1, input string name);
    logic [2:0] led;
    for (int j = j0; j <= j1; j++) begin
      for (int c = 0; c < 3; c++) led[c] = (32'(j) < cur[c]) ^ al;
      push_exp(dut, name, led, (j == p - 1), (j == p - 1) ? nxt : cur);
      step();
    end
  endtask

  initial begin
    // PERIOD=10, active-high
    val_r = 4; val_g = 0; val_b = 10;
    do_reset(0, 1'b0, 2);
    run_frame(0, 10, 1'b0, d3(0, 0, 0), d3(4, 0, 10), 0, 9, "first_period");
    run_frame(0, 10, 1'b0, d3(4, 0, 10), d3(4, 0, 10), 0, 9, "run_4_0_10");
    val_r = -5; val_g = 15; val_b = 32'sh7FFF_FFFF;
    run_frame(0, 10, 1'b0, d3(4, 0, 10), d3(0, 10, 10), 0, 9, "clamp_load");
    run_frame(0, 10, 1'b0, d3(0, 10, 10), d3(0, 10, 10), 0, 9, "clamped");
    val_r = 3;
    run_frame(0, 10, 1'b0, d3(0, 10, 10), d3(3, 10, 10), 0, 9, "load_3");
    run_frame(0, 10, 1'b0, d3(3, 10, 10), d3(7, 10, 10), 0, 4, "mid_change");
    val_r = 7;
    run_frame(0, 10, 1'b0, d3(3, 10, 10), d3(7, 10, 10), 5, 9, "mid_change");
    run_frame(0, 10, 1'b0, d3(7, 10, 10), d3(7, 10, 10), 0, 1, "glitch");
    val_r = 9;
    run_frame(0, 10, 1'b0, d3(7, 10, 10), d3(7, 10, 10), 2, 5, "glitch");
    val_r = 7;
    run_frame(0, 10, 1'b0, d3(7, 10, 10), d3(7, 10, 10), 6, 9, "glitch");
    run_frame(0, 10, 1'b0, d3(7, 10, 10), d3(7, 10, 10), 0, 5, "pre_reset");
    do_reset(0, 1'b0, 1);
    run_frame(0, 10, 1'b0, d3(0, 0, 0), d3(7, 10, 10), 0, 9, "post_reset");
    run_frame(0, 10, 1'b0, d3(7, 10, 10), d3(7, 10, 10), 0, 9, "post_reset_run");

    // PERIOD=10, active-low
    val_r = 2; val_g = 0; val_b = 10;
    do_reset(1, 1'b1, 2);
    run_frame(1, 10, 1'b1, d3(0, 0, 0), d3(2, 0, 10), 0, 9, "al_first");
    run_frame(1, 10, 1'b1, d3(2, 0, 10), d3(2, 0, 10), 0, 9, "al_run");
    run_frame(1, 10, 1'b1, d3(2, 0, 10), d3(2, 0, 10), 0, 9, "al_run2");

    // PERIOD=2 boundary
    val_r = 1; val_g = 0; val_b = 5;
    do_reset(2, 1'b0, 2);
    run_frame(2, 2, 1'b0, d3(0, 0, 0), d3(1, 0, 2), 0, 1, "p2_first");
    for (int k = 0; k < 3; k++)
      run_frame(2, 2, 1'b0, d3(1, 0, 2), d3(1, 0, 2), 0, 1, "p2_run");

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 96'(exp_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
